img_ram_port_arbiter: RTL
=========================

Name: img_ram_port_arbiter

Overview:
- Shares port A of the dual-port image RAM between two requesters.
- Writer: the image loader (DDR/cache fill). Reader: the downsample engine.
- Uses valid/grant handshakes with burst-lock round-robin arbitration.
- Drives registered address, data and write-enable to the RAM, and returns read data with a fixed-latency valid strobe. This replaces ad-hoc address-increment ready detection.

Parameters:
- ADDR_W, 19, RAM address width (covers the 263168-byte array).
- DATA_W, 8, pixel width.
- BURST_MAX, 16, maximum consecutive accepted beats for one owner while the other requester is pending; range 1..255.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_req  in  1  writer requests a write beat
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_gnt  out  1  beat accepted this cycle when wr_req&wr_gnt
- rd_req  in  1  reader requests a read beat
- rd_addr  in  ADDR_W  read address
- rd_gnt  out  1  beat accepted this cycle when rd_req&rd_gnt
- rd_data  out  DATA_W  read data, valid when rd_valid
- rd_valid  out  1  read data strobe
- ram_addr  out  ADDR_W  registered RAM port-A address
- ram_data  out  DATA_W  registered RAM port-A write data
- ram_we  out  1  registered RAM port-A write enable
- ram_q  in  DATA_W  RAM port-A registered read output
- owner  out  2  current owner: 0 NONE, 1 WR, 2 RD (debug)

Behaviour:
- Reset (async, rst_n=0):
  - owner=NONE; last_owner=RD, so the writer wins the first tie.
  - burst_cnt=0; ram_we=0; ram_addr=0; ram_data=0.
  - rd_valid=0; rd_data=0; the read pipeline flag is cleared.
  - In-flight reads are dropped and no rd_valid is issued for them.
- Grants are combinational from registered state and current requests. Exactly zero or one grant per cycle.
  - owner=NONE: if only one req, grant it. If both, grant the one not equal to last_owner.
  - owner=WR/RD: grant the owner if its req is high. If the owner req is low, grant the other if its req is high.
- Accept (req&gnt) at edge N:
  - ram_addr and ram_data are loaded from the accepted requester at edge N.
  - ram_we=1 for a write, 0 for a read, during cycle N+1.
  - A cycle with no accept loads ram_we=0 and holds ram_addr.
- Read latency: the RAM samples at edge N+1, and ram_q is valid during N+2.
  - rd_valid=1 and rd_data=ram_q (registered copy) during cycle N+2. Fixed 2 cycles from accept to data.
  - Back-to-back reads give one rd_valid per cycle, in order.
- Owner/burst update at each edge:
  - Accept by the current owner: burst_cnt++.
  - If burst_cnt+1==BURST_MAX and the other req is high: owner=other, burst_cnt=0, last_owner=old owner.
  - If the other req is low, burst_cnt saturates at BURST_MAX-1 and the owner keeps the port.
  - Accept by the non-owner (owner req low, or owner=NONE): owner=granted requester, burst_cnt=1, last_owner updated.
  - No req at all: owner=NONE, burst_cnt=0.
  - A handover costs no dead cycle; the new owner can be granted on the very next cycle.
- Ordering: a write followed next cycle by a read of the same address returns the new data, because RAM port A is write-then-read ordered by sequence.
- Requesters hold addr/data stable while req=1 and gnt=0. The arbiter does not latch unaccepted requests.
- Port B is not touched by this block.

Decomposition:
- Shared package img_ram_pkg: ADDR_W/DATA_W constants and owner encoding constants OWN_NONE=0, OWN_WR=1, OWN_RD=2.
- One sub-module, rr_burst_arb: 2-requester grant/owner/burst_cnt logic. The top level holds the RAM-side registers and the read-valid pipeline.

Test Plan:
- Reset mid-read: accept read at addr 5, assert rst_n=0 before N+2 -> rd_valid never pulses; ram_we=0, owner=0 immediately.
- Single write then read: write 0xA0 to addr 3, then read addr 3 -> ram_we=1 one cycle after the write accept; rd_valid exactly 2 cycles after the read accept with rd_data=0xA0.
- Simultaneous first requests: wr_req=rd_req=1 after reset -> wr_gnt=1 first cycle, rd_gnt=0; owner=1 next cycle.
- Burst lock, BURST_MAX=4, both requesting continuously -> grant pattern W,W,W,W,R,R,R,R,W…; no idle cycle between groups.
- Lone requester: rd_req held 40 cycles, wr_req=0 -> 40 consecutive rd_gnt, burst_cnt saturates at 3, owner stays 2; 40 rd_valid pulses, in address order 0..39 against preloaded data.
- Owner drops req: owner=WR at burst_cnt=2, wr_req falls while rd_req=1 -> rd_gnt the same cycle, owner=2, burst_cnt=1 next edge.

Source files
------------

// File: rtl/img_ram_pkg.sv
// Shared constants and owner encoding for the image RAM port-A arbiter.
// Used by the arbiter core, its bus interface and the top level.
package img_ram_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_WR   = 2'd1;
  localparam logic [1:0] OWN_RD   = 2'd2;

  typedef enum logic [1:0] {
    ST_NONE = OWN_NONE,
    ST_WR   = OWN_WR,
    ST_RD   = OWN_RD
  } own_e;

endpackage

// File: rtl/img_ram_port_arbiter_if.sv
// Bus bundle between the requesters/RAM (master) and the arbiter (slave).
// Ports: writer/reader req-gnt, read return, RAM port A, owner debug.
interface img_ram_port_arbiter_if #(
  parameter int ADDR_W = img_ram_pkg::ADDR_W,
  parameter int DATA_W = img_ram_pkg::DATA_W
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;
  logic [1:0]        owner;

  modport master (
    output wr_req, wr_addr, wr_data,
    output rd_req, rd_addr, ram_q,
    input  wr_gnt, rd_gnt, rd_data, rd_valid,
    input  ram_addr, ram_data, ram_we, owner
  );

  modport slave (
    input  wr_req, wr_addr, wr_data,
    input  rd_req, rd_addr, ram_q,
    output wr_gnt, rd_gnt, rd_data, rd_valid,
    output ram_addr, ram_data, ram_we, owner
  );
endinterface

// File: rtl/rr_burst_arb.sv
// Two-requester burst-locked round-robin grant, owner and burst counter.
// Ports: clk, rst_n, i_wr_req, i_rd_req -> o_wr_gnt, o_rd_gnt, o_owner.
module rr_burst_arb
  import img_ram_pkg::*;
#(
  parameter int BURST_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_req,
  input  logic       i_rd_req,
  output logic       o_wr_gnt,
  output logic       o_rd_gnt,
  output logic [1:0] o_owner
);

  localparam logic [7:0] CMAX = 8'(BURST_MAX - 1);

  own_e       r_own, w_own_nx;
  logic       r_last_rd, w_last_nx;
  logic [7:0] r_cnt, w_cnt_nx;
  logic       w_wr_pref;
  logic       w_idle;
  logic       w_acc_own;
  logic       w_oth_req;
  logic       w_at_max;

  // Preferred side: the owner, else the side that did not go last.
  always_comb begin
    w_wr_pref = r_last_rd;
    unique case (r_own)
      ST_WR:   w_wr_pref = 1'b1;
      ST_RD:   w_wr_pref = 1'b0;
      default: w_wr_pref = r_last_rd;
    endcase
  end

  assign o_wr_gnt = i_wr_req & (w_wr_pref | ~i_rd_req);
  assign o_rd_gnt = i_rd_req & (~w_wr_pref | ~i_wr_req);

  assign w_idle    = ~(o_wr_gnt | o_rd_gnt);
  assign w_acc_own = (r_own == ST_WR && o_wr_gnt) ||
                     (r_own == ST_RD && o_rd_gnt);
  assign w_oth_req = (r_own == ST_WR) ? i_rd_req : i_wr_req;
  assign w_at_max  = (int'(r_cnt) + 1) >= BURST_MAX;

  always_comb begin
    w_own_nx  = r_own;
    w_cnt_nx  = r_cnt;
    w_last_nx = r_last_rd;
    unique case (1'b1)
      w_idle: begin
        w_own_nx = ST_NONE;
        w_cnt_nx = '0;
      end
      w_acc_own: begin
        if (w_at_max && w_oth_req) begin
          w_own_nx  = (r_own == ST_WR) ? ST_RD : ST_WR;
          w_cnt_nx  = '0;
          w_last_nx = (r_own == ST_RD);
        end else if (int'(r_cnt) >= BURST_MAX - 1) begin
          w_cnt_nx = CMAX;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      default: begin
        w_own_nx  = o_wr_gnt ? ST_WR : ST_RD;
        w_cnt_nx  = 8'd1;
        w_last_nx = o_rd_gnt;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_own     <= ST_NONE;
      r_cnt     <= '0;
      r_last_rd <= 1'b1;
    end else begin
      r_own     <= w_own_nx;
      r_cnt     <= w_cnt_nx;
      r_last_rd <= w_last_nx;
    end
  end

  assign o_owner = r_own;

endmodule

// File: rtl/img_ram_port_arbiter.sv
// Shares image RAM port A between loader writes and downsample reads.
// Ports: clk, rst_n, bus (slave): req/gnt, RAM port A, read return.
module img_ram_port_arbiter #(
  parameter int ADDR_W    = img_ram_pkg::ADDR_W,
  parameter int DATA_W    = img_ram_pkg::DATA_W,
  parameter int BURST_MAX = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  img_ram_port_arbiter_if.slave bus
);

  logic              w_wr_gnt;
  logic              w_rd_gnt;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_data;
  logic              r_ram_we;
  logic              r_rd_p1;
  logic              r_rd_valid;

  rr_burst_arb #(
    .BURST_MAX(BURST_MAX)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_req (bus.wr_req),
    .i_rd_req (bus.rd_req),
    .o_wr_gnt (w_wr_gnt),
    .o_rd_gnt (w_rd_gnt),
    .o_owner  (bus.owner)
  );

  assign w_wr_acc = bus.wr_req & w_wr_gnt;
  assign w_rd_acc = bus.rd_req & w_rd_gnt;

  // Read flag rides beside the RAM's own output register, so
  // r_rd_valid lines up with ram_q two cycles after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_ram_we   <= 1'b0;
      r_rd_p1    <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_ram_we   <= w_wr_acc;
      r_rd_p1    <= w_rd_acc;
      r_rd_valid <= r_rd_p1;
      if (w_wr_acc) begin
        r_ram_addr <= bus.wr_addr;
        r_ram_data <= bus.wr_data;
      end else if (w_rd_acc) begin
        r_ram_addr <= bus.rd_addr;
      end
    end
  end

  assign bus.wr_gnt   = w_wr_gnt;
  assign bus.rd_gnt   = w_rd_gnt;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_data = r_ram_data;
  assign bus.ram_we   = r_ram_we;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_valid ? bus.ram_q : '0;

endmodule
